// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM stage request bundle plus MEM/WB results and stall.
// The upstream pipeline is the master; mem_stage is the slave.
interface mem_stage_if;
    logic        valid_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_addr_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        mem_to_reg_i;
    logic        reg_write_i;
    logic [1:0]  size_i;
    logic        ext_op_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_reg_write_o;
    logic        misalign_o;

    modport master (
        output valid_i, addr_i, wdata_i, rd_addr_i, mem_read_i, mem_write_i,
               mem_to_reg_i, reg_write_i, size_i, ext_op_i,
        input  stall_o, wb_valid_o, wb_data_o, wb_rd_o, wb_reg_write_o, misalign_o
    );

    modport slave (
        input  valid_i, addr_i, wdata_i, rd_addr_i, mem_read_i, mem_write_i,
               mem_to_reg_i, reg_write_i, size_i, ext_op_i,
        output stall_o, wb_valid_o, wb_data_o, wb_rd_o, wb_reg_write_o, misalign_o
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: sized loads/stores against a local word RAM,
// multi-cycle access with stall, and the MEM/WB boundary register.
module mem_stage #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mem_stage_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0] ram_q [DEPTH_WORDS];

    logic             aligned, is_mem, mem_op, misalign, last, stall;
    logic             load_sel, we;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wlanes, rword, rshift_b, rshift_h, ld_data;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_rw_q, wb_rw_d;
    logic        wb_mis_q, wb_mis_d;

    always_comb begin
        aligned = 1'b1;
        case (bus.size_i)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~bus.addr_i[0];
            default: aligned = (bus.addr_i[1:0] == 2'b00);
        endcase
    end

    assign is_mem   = bus.valid_i & (bus.mem_read_i | bus.mem_write_i);
    assign mem_op   = is_mem & aligned;
    assign misalign = is_mem & ~aligned;
    assign last     = (cnt_q == CNT_LAST);
    assign stall    = mem_op & ~last & rst_i;
    assign idx      = bus.addr_i[IDX_W+1:2];

    // With LATENCY=1 the counter never leaves 0, which is already the last cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (mem_op && !last) begin
                    state_d = BUSY;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            BUSY: begin
                if (!mem_op || last) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        be     = 4'b1111;
        wlanes = bus.wdata_i;
        case (bus.size_i)
            2'b00: begin
                be     = 4'b0001 << bus.addr_i[1:0];
                wlanes = {4{bus.wdata_i[7:0]}};
            end
            2'b01: begin
                be     = bus.addr_i[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{bus.wdata_i[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = bus.wdata_i;
            end
        endcase
    end

    // Gated by rst_i so a store caught by reset is dropped, not committed.
    assign we = mem_op & bus.mem_write_i & last & rst_i;

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) ram_q[idx][b*8 +: 8] <= wlanes[b*8 +: 8];
            end
        end
    end

    assign rword    = ram_q[idx];
    assign rshift_b = rword >> {bus.addr_i[1:0], 3'b000};
    assign rshift_h = rword >> {bus.addr_i[1], 4'b0000};

    always_comb begin
        ld_data = rword;
        case (bus.size_i)
            2'b00:   ld_data = {{24{bus.ext_op_i & rshift_b[7]}}, rshift_b[7:0]};
            2'b01:   ld_data = {{16{bus.ext_op_i & rshift_h[15]}}, rshift_h[15:0]};
            default: ld_data = rword;
        endcase
    end

    assign load_sel = bus.mem_to_reg_i & bus.mem_read_i & ~bus.mem_write_i & aligned;

    always_comb begin
        wb_valid_d = 1'b0;
        wb_data_d  = '0;
        wb_rd_d    = '0;
        wb_rw_d    = 1'b0;
        wb_mis_d   = 1'b0;
        if (!stall && bus.valid_i) begin
            wb_valid_d = 1'b1;
            wb_data_d  = load_sel ? ld_data : bus.addr_i;
            wb_rd_d    = bus.rd_addr_i;
            wb_rw_d    = bus.reg_write_i & ~misalign;
            wb_mis_d   = misalign;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_mis_q   <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

    assign bus.stall_o        = stall;
    assign bus.wb_valid_o     = wb_valid_q;
    assign bus.wb_data_o      = wb_data_q;
    assign bus.wb_rd_o        = wb_rd_q;
    assign bus.wb_reg_write_o = wb_rw_q;
    assign bus.misalign_o     = wb_mis_q;
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It consumes the EX/MEM pipeline register outputs and performs loads and stores against a local word-organised data RAM. Loads use byte/half/word sizing with sign or zero extension. The block raises a stall while a multi-cycle access is in flight and registers its results into the MEM/WB boundary for write-back.

## Interface
- DEPTH_WORDS, 256, data RAM depth in 32-bit words (power of two)
- LATENCY, 2, cycles per memory access (≥1)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  EX/MEM holds a valid instruction
- addr_i  in  32  ALU result: byte address, or pass-through result
- wdata_i  in  32  store data, right-aligned
- rd_addr_i  in  5  destination register
- mem_read_i  in  1  load
- mem_write_i  in  1  store
- mem_to_reg_i  in  1  write-back source is memory
- reg_write_i  in  1  instruction writes a register
- size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ext_op_i  in  1  1 sign-extends loads, 0 zero-extends
- stall_o  out  1  freeze PC/IF/ID/EX/MEM this cycle
- wb_valid_o  out  1  MEM/WB slot holds an instruction
- wb_data_o  out  32  load data or ALU result
- wb_rd_o  out  5  destination register
- wb_reg_write_o  out  1  write-back enable
- misalign_o  out  1  registered with the slot, marks a misaligned access

## Operation
- Memory op: valid_i & (mem_read_i | mem_write_i) & aligned.
  - Half is aligned when addr_i[0]=0.
  - Word is aligned when addr_i[1:0]=0.
- Word index is addr_i[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap. Byte order is little-endian.
- Cycle counter cnt (0..LATENCY-1) and state IDLE/BUSY:
  - IDLE→BUSY when a memory op is presented and LATENCY>1.
  - BUSY→IDLE when cnt reaches LATENCY-1.
- stall_o = memory op & (cnt != LATENCY-1). It is combinational from the inputs and cnt.
- Upstream holds all inputs stable while stall_o=1.
- Final access cycle (cnt=LATENCY-1):
  - A store commits on the closing edge, using byte lanes selected by size_i/addr_i[1:0].
  - A load reads the RAM in the same cycle. The preceding committed store is therefore visible.
- Both mem_read_i and mem_write_i set: treated as a store. wb_data_o = addr_i.
- Load extraction: the byte or half is selected by addr_i[1:0], then extended per ext_op_i. A word load is returned unchanged.
- wb_data_o = extended load data when mem_to_reg_i & mem_read_i, else addr_i.
- Misaligned access:
  - No RAM access and no stall; the slot advances next edge.
  - wb_valid_o=1, wb_reg_write_o=0, misalign_o=1.
- Non-memory instruction: passes to MEM/WB with 1-cycle latency, with wb_reg_write_o = reg_write_i.
- valid_i=0: MEM/WB loads a bubble (wb_valid_o=0, wb_reg_write_o=0).
- RAM contents are not reset.

## Timing
- Reset (rst_i=0, asynchronous):
  - wb_valid_o, wb_data_o, wb_rd_o, wb_reg_write_o and misalign_o all go to 0.
  - cnt=0 and state=IDLE.
  - stall_o is forced 0.
  - A store in progress is abandoned uncommitted.
- MEM/WB register loads on every rising edge where stall_o=0.
- During stall cycles MEM/WB loads a bubble, so no double write-back occurs.
- Memory op presented at cycle N:
  - stall_o is high for cycles N..N+LATENCY-2.
  - The result appears on wb_* in cycle N+LATENCY.
- LATENCY=1: stall_o is never asserted, and every instruction has 1-cycle latency.
- Back-to-back memory ops:
  - cnt returns to 0 on the edge that retires an op.
  - The next op starts counting in the following cycle with no idle gap.
- Reset release takes effect at the next rising edge. The first instruction after release behaves as from IDLE.

## Test plan
- LATENCY=2, sw 0xDEADBEEF @0x10, then lw @0x10:
  - Each op shows stall_o=1 for exactly one cycle.
  - The lw gives wb_data_o=0xDEADBEEF two cycles after presentation.
- sb 0x80 @0x13, then three loads:
  - lb (ext=1) @0x13 gives 0xFFFFFF80.
  - lbu (ext=0) @0x13 gives 0x00000080.
  - lw @0x10 gives 0x80ADBEEF.
- lh @0x11:
  - No stall.
  - Next cycle: misalign_o=1, wb_valid_o=1, wb_reg_write_o=0.
  - A following lw @0x10 is unaffected.
- ALU op, addr_i=0x1234, rd=5, reg_write=1:
  - No stall.
  - Next cycle: wb_data_o=0x1234, wb_rd_o=5, wb_reg_write_o=1.
  - valid_i=0 in the next cycle gives wb_valid_o=0 one cycle later.
- sw 0x22222222 @0x20, then sw 0x11111111 @0x20 with rst_i pulsed low during its stall cycle:
  - All outputs are 0 and stall_o=0 during reset.
  - After release, lw @0x20 returns 0x22222222.
- LATENCY=1 build:
  - Four back-to-back lw produce no stall.
  - Results appear on consecutive cycles with 1-cycle latency.
  - sw then lw to the same address returns the stored word.
